// File: rtl/operand_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | operand_stack : LIFO operand stack driven by stack_clk command strobes.    |
// | Optional OPERAND_STACK_NOS_EN adds nos_data output and pop2 input.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module operand_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stack_clk,
  input  logic              push,
  input  logic              pop,
`ifdef OPERAND_STACK_NOS_EN
  input  logic              pop2,
  output logic [DATA_W-1:0] nos_data,
`endif
  input  logic [DATA_W-1:0] data_to_push,
  output logic [DATA_W-1:0] data_from_stack,
  output logic [PTR_W-1:0]  sp,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err,
  output logic              op_done
);

  localparam int               c_idx_w = PTR_W - 1;
  localparam logic [PTR_W-1:0] c_depth = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] c_one   = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    sp_q;
  logic                stk_q;
  logic                push_q;
  logic                pop_q;
  logic [DATA_W-1:0]   data_q;
  logic                ovf_q;
  logic                unf_q;
  logic                done_q;
`ifdef OPERAND_STACK_NOS_EN
  logic                pop2_q;
`endif

  logic                w_cmd;
  logic                w_full;
  logic                w_empty;
  logic [c_idx_w-1:0]  w_wr_idx;
  logic [c_idx_w-1:0]  w_top_idx;

  assign w_cmd     = stack_clk & ~stk_q;
  assign w_full    = (sp_q == c_depth);
  assign w_empty   = (sp_q == '0);
  // Indices are only used when the matching full/empty guard holds, so truncation is safe.
  assign w_wr_idx  = c_idx_w'(sp_q);
  assign w_top_idx = c_idx_w'(sp_q - c_one);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q    <= '0;
      stk_q   <= 1'b0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef OPERAND_STACK_NOS_EN
      pop2_q  <= 1'b0;
`endif
    end else begin
      stk_q  <= stack_clk;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_cmd) begin
            push_q  <= push;
            pop_q   <= pop;
            data_q  <= data_to_push;
`ifdef OPERAND_STACK_NOS_EN
            pop2_q  <= pop2;
`endif
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (push_q && !pop_q) begin
            if (w_full) begin
              ovf_q <= 1'b1;
            end else begin
              mem_q[w_wr_idx] <= data_q;
              sp_q            <= sp_q + c_one;
            end
          end else if (!push_q && pop_q) begin
            if (w_empty) begin
              unf_q <= 1'b1;
`ifdef OPERAND_STACK_NOS_EN
            end else if (pop2_q) begin
              if (sp_q >= PTR_W'(2)) sp_q  <= sp_q - PTR_W'(2);
              else                   unf_q <= 1'b1;
`endif
            end else begin
              sp_q <= sp_q - c_one;
            end
          end else if (push_q && pop_q) begin
            // Replace-top: legal when full, since sp does not move.
            if (w_empty) unf_q <= 1'b1;
            else         mem_q[w_top_idx] <= data_q;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_from_stack = w_empty ? '0 : mem_q[w_top_idx];
  assign sp              = sp_q;
  assign full            = w_full;
  assign empty           = w_empty;
  assign overflow_err    = ovf_q;
  assign underflow_err   = unf_q;
  assign op_done         = done_q;

`ifdef OPERAND_STACK_NOS_EN
  logic [c_idx_w-1:0] w_nos_idx;
  assign w_nos_idx = c_idx_w'(sp_q - PTR_W'(2));
  assign nos_data  = (sp_q >= PTR_W'(2)) ? mem_q[w_nos_idx] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_operand_stack : directed self-checking bench for operand_stack.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_operand_stack;

  logic       clk;
  logic       reset;
  logic       stack_clk;
  logic       push;
  logic       pop;
  logic [7:0] data_to_push;
  logic [7:0] data_from_stack;
  logic [4:0] sp;
  logic       full;
  logic       empty;
  logic       overflow_err;
  logic       underflow_err;
  logic       op_done;
`ifdef OPERAND_STACK_NOS_EN
  logic       pop2;
  logic [7:0] nos_data;
`endif

  int err_cnt = 0;
  int chk_cnt = 0;
  int n_done;

  operand_stack #(.DATA_W(8), .DEPTH(16), .PTR_W(5)) u_dut (
    .clk             (clk),
    .reset           (reset),
    .stack_clk       (stack_clk),
    .push            (push),
    .pop             (pop),
`ifdef OPERAND_STACK_NOS_EN
    .pop2            (pop2),
    .nos_data        (nos_data),
`endif
    .data_to_push    (data_to_push),
    .data_from_stack (data_from_stack),
    .sp              (sp),
    .full            (full),
    .empty           (empty),
    .overflow_err    (overflow_err),
    .underflow_err   (underflow_err),
    .op_done         (op_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One command: strobe rises, inputs are scrambled during EXEC to prove they were latched.
  task automatic do_cmd(input logic p, input logic q, input logic [7:0] d);
    @(posedge clk); #1;
    push = p; pop = q; data_to_push = d; stack_clk = 1'b1;
    @(posedge clk); #1;
    stack_clk = 1'b0; push = ~p; pop = ~q; data_to_push = ~d;
    check_value("done_early", op_done, 1'b0);
    @(posedge clk); #1;
    check_value("done_pulse", op_done, 1'b1);
    @(posedge clk); #1;
    check_value("done_end", op_done, 1'b0);
    push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; stack_clk = 1'b0; push = 1'b0; pop = 1'b0; data_to_push = 8'h00;
`ifdef OPERAND_STACK_NOS_EN
    pop2 = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_sp", sp, 5'd0);
    check_value("rst_empty", empty, 1'b1);
    check_value("rst_full", full, 1'b0);
    check_value("rst_top", data_from_stack, 8'h00);
    check_value("rst_ovf", overflow_err, 1'b0);
    check_value("rst_unf", underflow_err, 1'b0);
    check_value("rst_done", op_done, 1'b0);
    reset = 1'b0;

    do_cmd(1'b1, 1'b0, 8'h11);
    do_cmd(1'b1, 1'b0, 8'h22);
    do_cmd(1'b1, 1'b0, 8'h33);
    check_value("push3_sp", sp, 5'd3);
    check_value("push3_top", data_from_stack, 8'h33);
    check_value("push3_empty", empty, 1'b0);

    do_cmd(1'b0, 1'b1, 8'h00);
    check_value("pop1_top", data_from_stack, 8'h22);
    do_cmd(1'b0, 1'b1, 8'h00);
    check_value("pop2_top", data_from_stack, 8'h11);
    check_value("pop2_sp", sp, 5'd1);
    do_cmd(1'b0, 1'b1, 8'h00);
    check_value("pop3_empty", empty, 1'b1);
    check_value("pop3_top", data_from_stack, 8'h00);
    check_value("pop3_unf", underflow_err, 1'b0);
    do_cmd(1'b0, 1'b1, 8'h00);
    check_value("pop4_unf", underflow_err, 1'b1);
    check_value("pop4_sp", sp, 5'd0);

    do_reset();
    for (int i = 0; i < 16; i++) do_cmd(1'b1, 1'b0, 8'(i));
    check_value("fill_full", full, 1'b1);
    check_value("fill_sp", sp, 5'd16);
    check_value("fill_top", data_from_stack, 8'h0F);
    check_value("fill_ovf", overflow_err, 1'b0);
    do_cmd(1'b1, 1'b0, 8'hAA);
    check_value("ovf_err", overflow_err, 1'b1);
    check_value("ovf_sp", sp, 5'd16);
    check_value("ovf_top", data_from_stack, 8'h0F);
    do_cmd(1'b1, 1'b1, 8'h55);
    check_value("repl_top", data_from_stack, 8'h55);
    check_value("repl_sp", sp, 5'd16);
    check_value("repl_unf", underflow_err, 1'b0);
    do_cmd(1'b0, 1'b1, 8'h00);
    check_value("repl_under_top", data_from_stack, 8'h0E);

    // Held strobe: must yield exactly one command.
    do_reset();
    @(posedge clk); #1;
    push = 1'b1; data_to_push = 8'h7E; stack_clk = 1'b1;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (op_done) n_done++;
    end
    stack_clk = 1'b0; push = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (op_done) n_done++;
    end
    check_value("held_ndone", n_done, 1);
    check_value("held_sp", sp, 5'd1);
    check_value("held_top", data_from_stack, 8'h7E);

    // Reset arrives during EXEC of a push.
    @(posedge clk); #1;
    push = 1'b1; data_to_push = 8'h44; stack_clk = 1'b1;
    @(posedge clk); #1;
    stack_clk = 1'b0; push = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check_value("mid_done0", op_done, 1'b0);
    check_value("mid_sp0", sp, 5'd0);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (op_done) n_done++;
    end
    check_value("mid_ndone", n_done, 0);
    check_value("mid_sp", sp, 5'd0);
    check_value("mid_top", data_from_stack, 8'h00);
    check_value("mid_ovf", overflow_err, 1'b0);
    check_value("mid_unf", underflow_err, 1'b0);
    do_cmd(1'b1, 1'b0, 8'h66);
    check_value("post_top", data_from_stack, 8'h66);

`ifdef OPERAND_STACK_NOS_EN
    do_reset();
    do_cmd(1'b1, 1'b0, 8'h05);
    check_value("nos_one", nos_data, 8'h00);
    do_cmd(1'b1, 1'b0, 8'h09);
    check_value("nos_val", nos_data, 8'h05);
    check_value("nos_top", data_from_stack, 8'h09);
    pop2 = 1'b1;
    do_cmd(1'b0, 1'b1, 8'h00);
    pop2 = 1'b0;
    check_value("pop2_sp0", sp, 5'd0);
    check_value("pop2_unf0", underflow_err, 1'b0);
    do_cmd(1'b1, 1'b0, 8'h01);
    pop2 = 1'b1;
    do_cmd(1'b0, 1'b1, 8'h00);
    pop2 = 1'b0;
    check_value("pop2_unf", underflow_err, 1'b1);
    check_value("pop2_sp1", sp, 5'd1);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
